// File: rtl/a0_uart_tx.sv
// a0_uart_tx: debug output path for the CPU.
// Captures every new value seen on register x10 (a0) into a small FIFO and
// sends each captured 32-bit word over an 8N1 UART line, least significant
// byte first. Consecutive words are separated by a single idle (pop) cycle.
//
// Capture handshake: a capture happens on a rising edge when en=1 and
// a0 differs from the last value seen while enabled. The capture is
// accepted when the FIFO has room at that edge, or when the transmitter
// pops the head word on that same edge. Otherwise the word is dropped and
// the sticky overflow flag is set.
module a0_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [31:0]                        a0,
    input  logic                               en,
    output logic                               tx,
    output logic                               busy,
    output logic                               overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // FSM and serialiser state
    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [1:0]          byte_q, byte_d;
    logic [31:0]         shift_q, shift_d;
    logic                tx_q, tx_d;

    // Capture and FIFO state
    logic [31:0]         last_a0_q, last_a0_d;
    logic                overflow_q, overflow_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [31:0]         mem_q [FIFO_DEPTH];

    logic                pop;
    logic                change;
    logic                push;
    logic                baud_end;
    logic [2:0]          nxt_bit;

    // Capture decision and FIFO bookkeeping
    always_comb begin
        pop        = (state_q == ST_IDLE) && (count_q != '0);
        change     = en && (a0 != last_a0_q);
        push       = change && ((count_q != CNT_W'(FIFO_DEPTH)) || pop);
        last_a0_d  = en ? a0 : last_a0_q;
        overflow_d = overflow_q | (change & ~push);
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // FIFO storage; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= a0;
        end
    end

    // Next-state, counters and registered tx value for the coming cycle
    always_comb begin
        state_d  = state_q;
        baud_d   = '0;
        bit_d    = bit_q;
        byte_d   = byte_q;
        shift_d  = shift_q;
        tx_d     = 1'b1;
        baud_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
        nxt_bit  = bit_q + 3'd1;
        if (state_q != ST_IDLE && !baud_end) begin
            baud_d = baud_q + BAUD_W'(1);
        end
        unique case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    state_d = ST_START;
                    shift_d = mem_q[rd_ptr_q];
                    byte_d  = 2'd0;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (baud_end) begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                tx_d = shift_q[bit_q];
                if (baud_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = nxt_bit;
                        tx_d  = shift_q[nxt_bit];
                    end
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (baud_end) begin
                    if (byte_q != 2'd3) begin
                        state_d = ST_START;
                        byte_d  = byte_q + 2'd1;
                        shift_d = {8'h00, shift_q[31:8]};
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any frame in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            last_a0_q  <= '0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            last_a0_q  <= last_a0_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = (state_q != ST_IDLE);
    assign overflow   = overflow_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_a0_uart_tx.sv
// Bench for a0_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Reference model works at word/frame level: a queue of captured words,
// a "line free at cycle" marker, and the expected line level computed from
// the offset into the current 40-bit frame.
module tb_a0_uart_tx;

    localparam int C     = 4;
    localparam int DEPTH = 4;
    localparam int WORD_CYC = 40 * C;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a0 = 32'h0;
    logic        en = 1'b0;
    logic        tx;
    logic        busy;
    logic        overflow;
    logic [2:0]  fifo_count;

    always #5 clk = ~clk;

    a0_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a0         (a0),
        .en         (en),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];      // words expected to appear on the line, in order

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mq[$];         // model FIFO contents
    logic [31:0] m_last;
    logic        m_ovf;
    logic [31:0] cur_word;
    int          cur_start;
    int          free_at;
    int          cyc = 0;

    // receiver state
    bit          rx_act;
    int          rx_cnt;
    int          rx_bytes;
    logic [7:0]  rx_byte;
    logic [31:0] rx_word;

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_last    = 32'h0;
        m_ovf     = 1'b0;
        cur_word  = 32'h0;
        cur_start = -1000000;
        free_at   = 0;
        rx_act    = 1'b0;
        rx_cnt    = 0;
        rx_bytes  = 0;
        rx_byte   = 8'h0;
        rx_word   = 32'h0;
    endtask

    // One rising edge of the model, using inputs as they were before the edge
    task automatic model_edge();
        cyc++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (cyc >= free_at && mq.size() > 0) begin
            cur_word  = mq.pop_front();
            cur_start = cyc;
            free_at   = cyc + WORD_CYC + 1;
        end
        if (en && a0 != m_last) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(a0);
                exp_q.push_back(a0);
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (en) m_last = a0;
    endtask

    function automatic logic model_busy();
        int off;
        off = cyc - cur_start;
        return (off >= 0) && (off < WORD_CYC);
    endfunction

    function automatic logic model_tx();
        int off, pos, byt;
        off = cyc - cur_start;
        if (off < 0 || off >= WORD_CYC) return 1'b1;
        byt = off / (10 * C);
        pos = (off % (10 * C)) / C;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return cur_word[byt * 8 + pos - 1];
    endfunction

    task automatic check_outputs();
        check("tx", 32'(tx), 32'(model_tx()));
        check("busy", 32'(busy), 32'(model_busy()));
        check("fifo_count", 32'(fifo_count), 32'(mq.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    // UART receiver sampling mid-bit; full words go to the scoreboard
    task automatic rx_sample();
        int k;
        if (!rx_act) begin
            if (tx !== 1'b0) return;
            rx_act = 1'b1;
            rx_cnt = 0;
        end
        if (rx_cnt % C == C / 2) begin
            k = rx_cnt / C;
            if (k == 0) begin
                check("rx_start", 32'(tx), 32'h0);
            end else if (k <= 8) begin
                rx_byte[k-1] = tx;
            end else begin
                check("rx_stop", 32'(tx), 32'h1);
                rx_word = {rx_byte, rx_word[31:8]};
                rx_bytes++;
                rx_act = 1'b0;
                if (rx_bytes == 4) begin
                    rx_bytes = 0;
                    if (exp_q.size() == 0) check("rx_unexpected_word", rx_word, 32'hdead_beef ^ rx_word ^ 32'h1);
                    else check("rx_word", rx_word, exp_q.pop_front());
                end
            end
        end
        rx_cnt++;
    endtask

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
        rx_sample();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    logic [31:0] w1;
    int hold;

    initial begin
        model_reset();
        // reset
        rst_n = 1'b0; en = 1'b0; a0 = 32'h0;
        run(3);
        check("rst_tx", 32'(tx), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_count", 32'(fifo_count), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        rst_n = 1'b1;

        // quiet: a0 held at 0 never captured
        en = 1'b1;
        run(500);

        // single word
        a0 = 32'h1234_5678;
        run(WORD_CYC + 10);

        // burst into a 4-deep FIFO; 6 is dropped
        for (int v = 1; v <= 6; v++) begin
            a0 = 32'(v);
            step();
        end
        run(5 * (WORD_CYC + 1) + 20);
        check("burst_ovf_sticky", 32'(overflow), 32'h1);

        // enable gating
        en = 1'b0;
        a0 = 32'h0; step();
        a0 = 32'hA; step();
        a0 = 32'hB; step();
        run(20);
        en = 1'b1;
        run(WORD_CYC + 10);
        en = 1'b0; run(5);
        en = 1'b1; run(5);
        en = 1'b0; run(5);
        en = 1'b1; run(50);

        // back-to-back pair
        a0 = $urandom; step();
        a0 = $urandom; step();
        run(2 * (WORD_CYC + 1) + 10);

        // randomized traffic
        for (int it = 0; it < 60; it++) begin
            en = ($urandom_range(0, 5) != 0);
            case ($urandom_range(0, 3))
                0: a0 = a0;
                1: a0 = $urandom;
                2: a0 = 32'($urandom_range(0, 3));
                default: a0 = a0 ^ (32'h1 << $urandom_range(0, 31));
            endcase
            hold = ($urandom_range(0, 4) == 0) ? $urandom_range(50, 200) : $urandom_range(1, 3);
            run(hold);
        end
        en = 1'b1;
        run(DEPTH * (WORD_CYC + 1) + 20);

        // reset mid-frame with two words outstanding
        w1 = $urandom | 32'h100;
        a0 = w1; step();
        a0 = 32'h0; step();
        run(50);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_tx", 32'(tx), 32'h1);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_count", 32'(fifo_count), 32'h0);
        check("midrst_ovf", 32'(overflow), 32'h0);
        run(3);
        rst_n = 1'b1;
        run(300);

        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/a0_uart_tx.md
Name: a0_uart_tx

Overview:
- Transmit side of the CPU's debug output path.
- Watches the register-file a0 output (x10) and captures every new value into a small FIFO.
- Serialises each captured 32-bit word over a one-wire UART (8N1) so a host or testbench can log program results without probing internal state.
- Sits at top level, between the register file's a0 port and the board/testbench tx pin.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit; must be >= 2.
- FIFO_DEPTH, 4, number of 32-bit words buffered; must be a power of two, >= 2.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a0  input  32  live value of register x10 from the register file.
- en  input  1  capture enable; when 0, a0 changes are ignored.
- tx  output  1  UART serial line, idle high.
- busy  output  1  high while a word is being shifted out (state != IDLE).
- overflow  output  1  sticky; set when a capture is dropped because the FIFO is full.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  words currently queued.

Behaviour:
- Reset (rst_n=0, async): tx=1, busy=0, overflow=0, fifo_count=0, last_a0=0, FSM=IDLE, baud/bit/byte counters=0. This applies immediately, including mid-frame; the partial frame is abandoned and not resent.
- Capture, evaluated every rising edge:
  - A push occurs when en=1 and a0 != last_a0; last_a0 <= a0 at the same edge.
  - When en=0, last_a0 is frozen. After re-enable, the first a0 differing from the frozen value is pushed.
  - a0 == 0 after reset is never pushed, because last_a0 resets to 0.
- Capture against a full FIFO:
  - If the FIFO is full and no pop occurs that edge, the word is dropped, overflow <= 1, and last_a0 is still updated.
  - A simultaneous push and pop while full are both accepted; fifo_count is unchanged.
- overflow is cleared only by reset.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO is non-empty at an edge, pop the head word into the shift register, byte_idx=0, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx = current byte bit[bit_idx], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then:
    - if byte_idx<3: byte_idx++, go to START (no extra idle between bytes);
    - otherwise go to IDLE.
- Byte order: least significant byte first (a0[7:0], a0[15:8], a0[23:16], a0[31:24]).
- Timing:
  - One word = 4 x 10 bits = 40*CLKS_PER_BIT cycles.
  - Consecutive words are separated by exactly one IDLE cycle (the pop cycle), tx=1.
- Latency: if a0 changes before edge k (en=1, FIFO empty, FSM IDLE), the word is written at edge k, popped at edge k+1, and tx falls at edge k+1.
- The baud counter counts 0..CLKS_PER_BIT-1 and wraps. No fractional baud.
- tx is driven from a register; no combinational path from a0 to tx.
- fifo_count:
  - +1 on push only, -1 on pop only, unchanged on both or neither.
  - Never exceeds FIFO_DEPTH and never underflows; pop is only issued when non-empty.
- FIFO pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Single word: CLKS_PER_BIT=4, reset, then a0=0x12345678 with en=1 → tx falls one edge after capture. Decoded bytes are 0x78,0x56,0x34,0x12, each with start=0 and stop=1. Frame lasts 160 cycles, then busy=0 and fifo_count=0.
- Quiet: a0 held at 0 after reset for 500 cycles → tx stays 1, busy=0, fifo_count=0, no push.
- Burst/overflow: FIFO_DEPTH=4, a0=1,2,3,4,5,6 on six consecutive edges → values 1..5 are transmitted in order, 6 is dropped, and overflow=1 stays set after the line drains.
- Enable gating:
  - en=0 while a0 goes 0→0xA→0xB → nothing is queued.
  - en=1 with a0=0xB → exactly one word, 0x0000000B, is sent.
  - Toggling en with a0 unchanged → no further sends.
- Back-to-back: two words queued → exactly one tx=1 idle cycle between the last stop bit of word 1 and the start bit of word 2.
- Reset mid-frame: assert rst_n=0 during DATA of byte 2 with 2 words queued → tx=1, busy=0, fifo_count=0, overflow=0 immediately. After release with a0 unchanged, nothing is sent.
